// File: rtl/mulf16_pkg.sv
// mulf16_pkg: shared constants and types for the 17-bit float multiply
// (and the divider's post-normalization).
//   EXP_BIAS / MAN_W / EXP_W : format constants
//   state_t                  : sequencer states (IDLE, MUL, NORM)
//   exp_s10_t                : 10-bit signed exponent used for flag logic
package mulf16_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MAN_W    = 8;
  localparam int EXP_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

  // Wide enough for a_exp + b_exp - bias + 1 with both signs.
  typedef logic signed [9:0] exp_s10_t;

endpackage

// File: rtl/mulf16_norm.sv
// mulf16_norm: combinational normalize / exponent / flag logic.
// Ports:
//   i_p      : raw mantissa product (2*MAN_W bits, two integer bits)
//   i_a_exp  : biased exponent of operand A
//   i_b_exp  : biased exponent of operand B
//   i_zero   : either operand mantissa is zero
//   o_man    : truncated normalized mantissa (explicit leading one)
//   o_exp    : biased result exponent
//   o_ovf    : exponent overflow (result saturated to all ones)
//   o_unf    : exponent underflow (result flushed to zero)
module mulf16_norm #(
  parameter int EXP_BIAS = mulf16_pkg::EXP_BIAS,
  parameter int MAN_W    = mulf16_pkg::MAN_W,
  parameter int EXP_W    = mulf16_pkg::EXP_W
) (
  input  logic [2*MAN_W-1:0] i_p,
  input  logic [EXP_W-1:0]   i_a_exp,
  input  logic [EXP_W-1:0]   i_b_exp,
  input  logic               i_zero,
  output logic [MAN_W-1:0]   o_man,
  output logic [EXP_W-1:0]   o_exp,
  output logic               o_ovf,
  output logic               o_unf
);
  import mulf16_pkg::*;

  localparam exp_s10_t EXP_MAX = exp_s10_t'((1 << EXP_W) - 1);

  logic               w_p_top;
  logic [MAN_W-1:0]   w_man;
  exp_s10_t           w_e_sum;
  exp_s10_t           w_e;

  // Product of two [1,2) values lies in [1,4): the top bit decides whether
  // a one-place right shift (and exponent bump) is needed.
  assign w_p_top = i_p[2*MAN_W-1];
  assign w_man   = w_p_top ? i_p[2*MAN_W-1:MAN_W] : i_p[2*MAN_W-2:MAN_W-1];

  assign w_e_sum = exp_s10_t'({{(10-EXP_W){1'b0}}, i_a_exp})
                 + exp_s10_t'({{(10-EXP_W){1'b0}}, i_b_exp})
                 - exp_s10_t'(EXP_BIAS);
  assign w_e     = w_p_top ? (w_e_sum + 10'sd1) : w_e_sum;

  // A zero operand wins over both range checks.
  always_comb begin
    o_man = '0;
    o_exp = '0;
    o_ovf = 1'b0;
    o_unf = 1'b0;
    if (!i_zero) begin
      if (w_e >= EXP_MAX) begin
        o_man = '1;
        o_exp = '1;
        o_ovf = 1'b1;
      end else if (w_e <= 10'sd0) begin
        o_unf = 1'b1;
      end else begin
        o_man = w_man;
        o_exp = w_e[EXP_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mulf16_seq.sv
// mulf16_seq: sequential 17-bit float multiplier (sign, 8-bit biased
// exponent, 8-bit mantissa with explicit leading one). One shift-add step
// per mantissa bit, then a single normalize cycle.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : request, accepted only in IDLE
//   a_* / b_*                : operands, latched on acceptance
//   busy                     : acceptance through the done cycle
//   done                     : one-cycle result-valid pulse
//   product_* / overflow /
//   underflow                : registered results, held until next done
module mulf16_seq #(
  parameter int EXP_BIAS = mulf16_pkg::EXP_BIAS,
  parameter int MAN_W    = mulf16_pkg::MAN_W,
  parameter int EXP_W    = mulf16_pkg::EXP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W-1:0] a_mantissa,
  input  logic             a_sign,
  input  logic [EXP_W-1:0] a_exponent,
  input  logic [MAN_W-1:0] b_mantissa,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] b_exponent,
  output logic             busy,
  output logic             done,
  output logic [MAN_W-1:0] product_mantissa,
  output logic             product_sign,
  output logic [EXP_W-1:0] product_exponent,
  output logic             overflow,
  output logic             underflow
);
  import mulf16_pkg::*;

  localparam int                CNT_W    = $clog2(MAN_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAN_W - 1);

  state_t               r_state;
  logic [MAN_W-1:0]     r_a_man;
  logic [MAN_W-1:0]     r_b_man;
  logic                 r_a_sign;
  logic                 r_b_sign;
  logic [EXP_W-1:0]     r_a_exp;
  logic [EXP_W-1:0]     r_b_exp;
  logic [2*MAN_W-1:0]   r_acc;
  logic [CNT_W-1:0]     r_count;

  logic [2*MAN_W-1:0]   w_pp;
  logic                 w_zero;
  logic [MAN_W-1:0]     w_norm_man;
  logic [EXP_W-1:0]     w_norm_exp;
  logic                 w_norm_ovf;
  logic                 w_norm_unf;

  // Partial product for the multiplier bit under the counter.
  assign w_pp   = r_b_man[r_count] ? ({{MAN_W{1'b0}}, r_a_man} << r_count) : '0;
  assign w_zero = (r_a_man == '0) || (r_b_man == '0);

  mulf16_norm #(
    .EXP_BIAS (EXP_BIAS),
    .MAN_W    (MAN_W),
    .EXP_W    (EXP_W)
  ) u_norm (
    .i_p     (r_acc),
    .i_a_exp (r_a_exp),
    .i_b_exp (r_b_exp),
    .i_zero  (w_zero),
    .o_man   (w_norm_man),
    .o_exp   (w_norm_exp),
    .o_ovf   (w_norm_ovf),
    .o_unf   (w_norm_unf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_a_man          <= '0;
      r_b_man          <= '0;
      r_a_sign         <= 1'b0;
      r_b_sign         <= 1'b0;
      r_a_exp          <= '0;
      r_b_exp          <= '0;
      r_acc            <= '0;
      r_count          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      product_mantissa <= '0;
      product_sign     <= 1'b0;
      product_exponent <= '0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          // busy stays up through the done cycle and drops here unless a
          // new request is taken on the same edge.
          if (start) begin
            r_a_man  <= a_mantissa;
            r_b_man  <= b_mantissa;
            r_a_sign <= a_sign;
            r_b_sign <= b_sign;
            r_a_exp  <= a_exponent;
            r_b_exp  <= b_exponent;
            r_acc    <= '0;
            r_count  <= '0;
            busy     <= 1'b1;
            r_state  <= MUL;
          end else begin
            busy     <= 1'b0;
          end
        end
        MUL: begin
          r_acc <= r_acc + w_pp;
          if (r_count == CNT_LAST) begin
            r_state <= NORM;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        NORM: begin
          product_mantissa <= w_norm_man;
          product_exponent <= w_norm_exp;
          product_sign     <= r_a_sign ^ r_b_sign;
          overflow         <= w_norm_ovf;
          underflow        <= w_norm_unf;
          done             <= 1'b1;
          r_state          <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mulf16_seq.sv
// tb_mulf16_seq: directed-vector bench for mulf16_seq. Results are packed
// as {overflow, underflow, sign, exponent[7:0], mantissa[7:0]}.
module tb_mulf16_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_mantissa;
  logic       a_sign;
  logic [7:0] a_exponent;
  logic [7:0] b_mantissa;
  logic       b_sign;
  logic [7:0] b_exponent;
  logic       busy;
  logic       done;
  logic [7:0] product_mantissa;
  logic       product_sign;
  logic [7:0] product_exponent;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mulf16_seq dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .a_mantissa       (a_mantissa),
    .a_sign           (a_sign),
    .a_exponent       (a_exponent),
    .b_mantissa       (b_mantissa),
    .b_sign           (b_sign),
    .b_exponent       (b_exponent),
    .busy             (busy),
    .done             (done),
    .product_mantissa (product_mantissa),
    .product_sign     (product_sign),
    .product_exponent (product_exponent),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] res_now();
    return {overflow, underflow, product_sign, product_exponent, product_mantissa};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input logic [7:0] am, input logic as, input logic [7:0] ae,
                         input logic [7:0] bm, input logic bs, input logic [7:0] be);
    a_mantissa = am; a_sign = as; a_exponent = ae;
    b_mantissa = bm; b_sign = bs; b_exponent = be;
  endtask

  // Waits up to 20 edges for done; returns edges elapsed (0 = timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] am, input logic as, input logic [7:0] ae,
                        input logic [7:0] bm, input logic bs, input logic [7:0] be,
                        input logic [18:0] exp_res);
    int lat;
    @(negedge clk);
    set_ops(am, as, ae, bm, bs, be);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_on"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " result"}, 32'(res_now()), 32'(exp_res));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, " done_off"}, 32'(done), 32'd0);
    check({tag, " busy_off"}, 32'(busy), 32'd0);
    $display("op %s: lat=%0d result=%h expected=%h", tag, lat, res_now(), exp_res);
  endtask

  initial begin
    int lat;
    int n_done;
    int t_done [4];
    int saw_done;

    rst = 1'b1;
    start = 1'b0;
    set_ops(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(res_now()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //       tag            am    as  ae      bm    bs  be      {ovf,unf,sign,exp,man}
    run_op("one_x_one",    8'h80, 0, 8'd127, 8'h80, 0, 8'd127, {1'b0,1'b0,1'b0,8'd127,8'h80});
    run_op("1p5_x_m1p5",   8'hC0, 0, 8'd127, 8'hC0, 1, 8'd127, {1'b0,1'b0,1'b1,8'd128,8'h90});
    run_op("overflow",     8'h80, 0, 8'd200, 8'h80, 0, 8'd200, {1'b1,1'b0,1'b0,8'hFF,8'hFF});
    run_op("underflow",    8'h80, 0, 8'd20,  8'h80, 0, 8'd20,  {1'b0,1'b1,1'b0,8'd0,8'h00});
    run_op("zero_a",       8'h00, 0, 8'd200, 8'hFF, 0, 8'd200, {1'b0,1'b0,1'b0,8'd0,8'h00});
    run_op("zero_sign",    8'h00, 1, 8'd127, 8'hA0, 0, 8'd127, {1'b0,1'b0,1'b1,8'd0,8'h00});
    run_op("zero_b_unf",   8'h90, 1, 8'd1,   8'h00, 1, 8'd1,   {1'b0,1'b0,1'b0,8'd0,8'h00});
    run_op("ff_x_ff",      8'hFF, 0, 8'd127, 8'hFF, 0, 8'd127, {1'b0,1'b0,1'b0,8'd128,8'hFE});
    run_op("truncate",     8'h81, 1, 8'd100, 8'hA0, 1, 8'd150, {1'b0,1'b0,1'b0,8'd123,8'hA1});
    run_op("exp_254",      8'h80, 0, 8'd190, 8'h80, 0, 8'd191, {1'b0,1'b0,1'b0,8'd254,8'h80});
    run_op("exp_255",      8'h80, 0, 8'd191, 8'h80, 1, 8'd191, {1'b1,1'b0,1'b1,8'hFF,8'hFF});
    run_op("bump_to_255",  8'hC0, 0, 8'd191, 8'hC0, 0, 8'd190, {1'b1,1'b0,1'b0,8'hFF,8'hFF});
    run_op("exp_0",        8'h80, 0, 8'd64,  8'h80, 0, 8'd63,  {1'b0,1'b1,1'b0,8'd0,8'h00});
    run_op("exp_1",        8'h80, 0, 8'd64,  8'h80, 0, 8'd64,  {1'b0,1'b0,1'b0,8'd1,8'h80});

    // Operand changes and a stray start during MUL must not disturb the result.
    @(negedge clk);
    set_ops(8'hC0, 1'b0, 8'd127, 8'hC0, 1'b1, 8'd127);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    set_ops(8'hFF, 1'b1, 8'd3, 8'h81, 1'b1, 8'd250);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 5; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("hold latency", 32'(lat), 32'd9);
    check("hold result", 32'(res_now()), 32'({1'b0,1'b0,1'b1,8'd128,8'h90}));
    @(posedge clk); #1;
    check("hold no_requeue", 32'(busy), 32'd0);
    $display("op hold_operands: lat=%0d result=%h", lat, res_now());

    // start held high: one result every 10 cycles.
    @(negedge clk);
    set_ops(8'h80, 1'b0, 8'd127, 8'h80, 1'b0, 8'd127);
    start = 1'b1;
    n_done = 0;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk); #1;
      if (done && n_done < 4) begin
        t_done[n_done] = cyc;
        n_done++;
      end
    end
    start = 1'b0;
    check("stream count", 32'(n_done), 32'd3);
    check("stream gap1", 32'(t_done[1] - t_done[0]), 32'd10);
    check("stream gap2", 32'(t_done[2] - t_done[1]), 32'd10);
    check("stream result", 32'(res_now()), 32'({1'b0,1'b0,1'b0,8'd127,8'h80}));
    $display("op stream: dones=%0d gaps=%0d,%0d", n_done, t_done[1] - t_done[0], t_done[2] - t_done[1]);
    lat = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (!busy) begin
        lat = k;
        break;
      end
    end
    check("stream drain", 32'(lat != 0), 32'd1);

    // Reset four cycles after acceptance aborts the operation.
    @(negedge clk);
    set_ops(8'hC0, 1'b0, 8'd127, 8'hC0, 1'b1, 8'd127);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(res_now()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);
    $display("op abort: busy=%0d done=%0d result=%h", busy, done, res_now());
    run_op("after_abort",  8'hC0, 0, 8'd127, 8'hC0, 1, 8'd127, {1'b0,1'b0,1'b1,8'd128,8'h90});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
